// File: rtl/dmem_arb_pkg.sv
// Shared types and default sizing for the data-memory arbiter.
package dmem_arb_pkg;

    localparam int DEF_AW       = 32;
    localparam int DEF_DW       = 32;
    localparam int DEF_MAX_WAIT = 4;
    localparam int DEF_CW       = 4;

    typedef enum logic {
        IDLE = 1'b0,
        ACK  = 1'b1
    } arb_state_t;

endpackage

// File: rtl/arb_wait_counter.sv
// Saturating count of consecutive cycles the external master has been denied.
module arb_wait_counter
    import dmem_arb_pkg::*;
#(
    parameter int CW  = DEF_CW,
    parameter int MAX = DEF_MAX_WAIT
) (
    input  logic clk,
    input  logic reset,
    input  logic inc,
    input  logic clr,
    input  logic hold,
    output logic at_max
);

    localparam logic [CW-1:0] MAX_V = CW'(MAX);

    logic [CW-1:0] cnt;

    // hold wins over clr so the count is frozen while an ack is in flight
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt <= '0;
        end else if (!hold) begin
            if (clr) begin
                cnt <= '0;
            end else if (inc && (cnt != MAX_V)) begin
                cnt <= cnt + 1'b1;
            end
        end
    end

    assign at_max = (cnt == MAX_V);

endmodule

// File: rtl/dmem_arbiter.sv
// Shares single-port dmem between the processor (fixed priority) and an
// external req/ack master, with a starvation-forced ext grant.
//
//   state | meaning
//   IDLE  | processor owns dmem unless ext is granted this cycle
//   ACK   | ext transfer done, ext_ack high, processor owns dmem
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int AW       = DEF_AW,
    parameter int DW       = DEF_DW,
    parameter int MAX_WAIT = DEF_MAX_WAIT,
    parameter int CW       = DEF_CW
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          cpu_re,
    input  logic          cpu_we,
    input  logic [AW-1:0] cpu_adr,
    input  logic [DW-1:0] cpu_wd,
    output logic [DW-1:0] cpu_rd,
    output logic          cpu_stall,
    input  logic          ext_req,
    input  logic          ext_we,
    input  logic [AW-1:0] ext_adr,
    input  logic [DW-1:0] ext_wd,
    output logic          ext_ack,
    output logic [DW-1:0] ext_rd,
    output logic          mem_we,
    output logic [AW-1:0] mem_a,
    output logic [DW-1:0] mem_wd,
    input  logic [DW-1:0] mem_rd
);

    arb_state_t state, state_nxt;
    logic       cpu_acc;
    logic       ext_gnt;
    logic       at_max;

    assign cpu_acc = cpu_re | cpu_we;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // gating with reset keeps dmem untouched while reset is asserted
    always_comb begin
        state_nxt = state;
        ext_gnt   = 1'b0;
        case (state)
            IDLE: begin
                ext_gnt = reset & ext_req & (~cpu_acc | at_max);
                if (ext_gnt) begin
                    state_nxt = ACK;
                end
            end
            ACK: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    assign cpu_stall = cpu_acc & ext_gnt;
    assign ext_ack   = (state == ACK);
    assign cpu_rd    = mem_rd;

    always_comb begin
        mem_a  = cpu_adr;
        mem_wd = cpu_wd;
        mem_we = reset & cpu_we & ~cpu_stall;
        if (ext_gnt) begin
            mem_a  = ext_adr;
            mem_wd = ext_wd;
            mem_we = ext_we;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ext_rd <= '0;
        end else if (ext_gnt && !ext_we) begin
            ext_rd <= mem_rd;
        end
    end

    arb_wait_counter #(
        .CW  (CW),
        .MAX (MAX_WAIT)
    ) u_wait (
        .clk    (clk),
        .reset  (reset),
        .inc    (ext_req & ~ext_gnt),
        .clr    (ext_gnt | ~ext_req),
        .hold   (state == ACK),
        .at_max (at_max)
    );

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter: directed scenarios plus a randomized
// run against a transaction-level reference model.
module tb_dmem_arbiter;

    localparam int MAX_WAIT = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        cpu_re, cpu_we;
    logic [31:0] cpu_adr, cpu_wd, cpu_rd;
    logic        cpu_stall;
    logic        ext_req, ext_we;
    logic [31:0] ext_adr, ext_wd, ext_rd;
    logic        ext_ack;
    logic        mem_we;
    logic [31:0] mem_a, mem_wd, mem_rd;

    int total = 0;
    int bad   = 0;

    logic [31:0] dmem    [0:255];
    logic [31:0] ref_mem [0:255];

    always #5 clk = ~clk;

    assign mem_rd = dmem[mem_a[9:2]];
    always @(posedge clk) begin
        if (mem_we) dmem[mem_a[9:2]] <= mem_wd;
    end

    dmem_arbiter #(
        .AW(32), .DW(32), .MAX_WAIT(MAX_WAIT), .CW(4)
    ) dut (
        .clk(clk), .reset(reset),
        .cpu_re(cpu_re), .cpu_we(cpu_we), .cpu_adr(cpu_adr), .cpu_wd(cpu_wd),
        .cpu_rd(cpu_rd), .cpu_stall(cpu_stall),
        .ext_req(ext_req), .ext_we(ext_we), .ext_adr(ext_adr), .ext_wd(ext_wd),
        .ext_ack(ext_ack), .ext_rd(ext_rd),
        .mem_we(mem_we), .mem_a(mem_a), .mem_wd(mem_wd), .mem_rd(mem_rd)
    );

    task automatic idle_inputs();
        cpu_re = 0; cpu_we = 0; cpu_adr = 32'h10; cpu_wd = 0;
        ext_req = 0; ext_we = 0; ext_adr = 0; ext_wd = 0;
    endtask

    task automatic test_reset();
        reset = 0;
        cpu_re = 0; cpu_we = 1; cpu_adr = 32'h10; cpu_wd = 32'h12345678;
        ext_req = 1; ext_we = 1; ext_adr = 32'h40; ext_wd = 32'h0BADF00D;
        repeat (2) @(negedge clk);
        #1;
        total++; if (ext_ack !== 1'b0) begin bad++; $display("FAIL rst_ack got=%b exp=0", ext_ack); end
        total++; if (ext_rd !== 32'h0) begin bad++; $display("FAIL rst_rd got=%h exp=0", ext_rd); end
        total++; if (mem_we !== 1'b0) begin bad++; $display("FAIL rst_mem_we got=%b exp=0", mem_we); end
        total++; if (cpu_stall !== 1'b0) begin bad++; $display("FAIL rst_stall got=%b exp=0", cpu_stall); end
        @(negedge clk);
        reset = 1;
        #1;
        total++; if (mem_a !== 32'h10 || cpu_stall !== 1'b0 || mem_we !== 1'b1) begin
            bad++; $display("FAIL rel_cpu_wins mem_a=%h stall=%b we=%b exp a=10 stall=0 we=1", mem_a, cpu_stall, mem_we);
        end
        @(negedge clk);
        cpu_we = 0;
        #1;
        total++; if (mem_a !== 32'h40 || mem_we !== 1'b1) begin
            bad++; $display("FAIL rel_ext_gnt mem_a=%h we=%b exp a=40 we=1", mem_a, mem_we);
        end
        @(negedge clk);
        ext_req = 0;
        #1;
        total++; if (ext_ack !== 1'b1) begin bad++; $display("FAIL rel_ack got=%b exp=1", ext_ack); end
        @(negedge clk);
        #1;
        total++; if (ext_ack !== 1'b0) begin bad++; $display("FAIL rel_ack_end got=%b exp=0", ext_ack); end
    endtask

    task automatic test_ext_write();
        idle_inputs();
        @(negedge clk);
        ext_req = 1; ext_we = 1; ext_adr = 32'h40; ext_wd = 32'hDEADBEEF;
        #1;
        total++; if (mem_we !== 1'b1 || mem_a !== 32'h40 || mem_wd !== 32'hDEADBEEF) begin
            bad++; $display("FAIL wr_mux we=%b a=%h wd=%h exp 1/40/deadbeef", mem_we, mem_a, mem_wd);
        end
        @(negedge clk);
        ext_req = 0;
        #1;
        total++; if (ext_ack !== 1'b1) begin bad++; $display("FAIL wr_ack got=%b exp=1", ext_ack); end
        @(negedge clk);
        #1;
        total++; if (dmem[16] !== 32'hDEADBEEF || ext_ack !== 1'b0) begin
            bad++; $display("FAIL wr_mem mem=%h ack=%b exp deadbeef/0", dmem[16], ext_ack);
        end
    endtask

    task automatic test_ext_read();
        idle_inputs();
        @(negedge clk);
        ext_req = 1; ext_we = 0; ext_adr = 32'h40;
        #1;
        total++; if (cpu_stall !== 1'b0 || mem_we !== 1'b0 || mem_a !== 32'h40) begin
            bad++; $display("FAIL rd_gnt stall=%b we=%b a=%h exp 0/0/40", cpu_stall, mem_we, mem_a);
        end
        @(negedge clk);
        ext_req = 0;
        #1;
        total++; if (ext_ack !== 1'b1 || ext_rd !== 32'hDEADBEEF || cpu_stall !== 1'b0) begin
            bad++; $display("FAIL rd_ack ack=%b rd=%h stall=%b exp 1/deadbeef/0", ext_ack, ext_rd, cpu_stall);
        end
    endtask

    task automatic test_starvation();
        idle_inputs();
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            if (c == 0) begin
                cpu_re = 1; cpu_adr = 32'h10;
                ext_req = 1; ext_we = 1; ext_adr = 32'h84; ext_wd = 32'hA5A5A5A5;
            end
            #1;
            total++; if (cpu_stall !== 1'b0 || mem_a !== 32'h10 || ext_ack !== 1'b0) begin
                bad++; $display("FAIL starve_c%0d stall=%b a=%h ack=%b exp 0/10/0", c, cpu_stall, mem_a, ext_ack);
            end
        end
        @(negedge clk);
        cpu_re = 0; cpu_we = 1; cpu_adr = 32'h80; cpu_wd = 32'h11111111;
        #1;
        total++; if (cpu_stall !== 1'b1 || mem_a !== 32'h84 || mem_we !== 1'b1 || mem_wd !== 32'hA5A5A5A5) begin
            bad++; $display("FAIL starve_force stall=%b a=%h we=%b wd=%h exp 1/84/1/a5a5a5a5", cpu_stall, mem_a, mem_we, mem_wd);
        end
        @(negedge clk);
        ext_req = 0;
        #1;
        total++; if (ext_ack !== 1'b1 || cpu_stall !== 1'b0 || mem_a !== 32'h80 || mem_we !== 1'b1 || mem_wd !== 32'h11111111) begin
            bad++; $display("FAIL starve_ack ack=%b stall=%b a=%h we=%b wd=%h exp 1/0/80/1/11111111", ext_ack, cpu_stall, mem_a, mem_we, mem_wd);
        end
        total++; if (dmem[32] !== 32'h0) begin bad++; $display("FAIL stalled_write_landed mem=%h exp=0", dmem[32]); end
        @(negedge clk);
        cpu_we = 0;
        #1;
        total++; if (dmem[32] !== 32'h11111111 || dmem[33] !== 32'hA5A5A5A5 || mem_we !== 1'b0) begin
            bad++; $display("FAIL starve_mem m80=%h m84=%h we=%b exp 11111111/a5a5a5a5/0", dmem[32], dmem[33], mem_we);
        end
    endtask

    task automatic test_back_to_back();
        idle_inputs();
        @(negedge clk);
        ext_req = 1; ext_we = 0; ext_adr = 32'h40;
        #1;
        total++; if (mem_a !== 32'h40 || ext_ack !== 1'b0) begin bad++; $display("FAIL b2b_g0 a=%h ack=%b exp 40/0", mem_a, ext_ack); end
        @(negedge clk); #1;
        total++; if (ext_ack !== 1'b1 || mem_a !== 32'h10 || ext_rd !== 32'hDEADBEEF) begin
            bad++; $display("FAIL b2b_a0 ack=%b a=%h rd=%h exp 1/10/deadbeef", ext_ack, mem_a, ext_rd);
        end
        @(negedge clk); #1;
        total++; if (ext_ack !== 1'b0 || mem_a !== 32'h40) begin bad++; $display("FAIL b2b_g1 ack=%b a=%h exp 0/40", ext_ack, mem_a); end
        @(negedge clk); #1;
        total++; if (ext_ack !== 1'b1) begin bad++; $display("FAIL b2b_a1 ack=%b exp 1", ext_ack); end
        #1 reset = 0;
        #1;
        total++; if (ext_ack !== 1'b0 || ext_rd !== 32'h0) begin
            bad++; $display("FAIL b2b_rst ack=%b rd=%h exp 0/0", ext_ack, ext_rd);
        end
        @(negedge clk);
        ext_req = 0; reset = 1;
        @(negedge clk); #1;
        total++; if (ext_ack !== 1'b0) begin bad++; $display("FAIL b2b_post ack=%b exp 0", ext_ack); end
    endtask

    // Reference: the ext master gets memory when the cpu is idle or after it
    // has been turned away MAX_WAIT times in a row; ack follows one cycle later.
    task automatic test_random();
        logic        m_ack, pend, gnt, e_stall, e_we, cpu_acc, heavy;
        logic [31:0] e_a, e_wd, exp_rd;
        logic [7:0]  idx;
        int          denied;
        idle_inputs();
        reset = 0;
        @(negedge clk);
        reset = 1;
        @(negedge clk);
        m_ack = 0; pend = 0; denied = 0; exp_rd = 0;
        for (int cyc = 0; cyc < 2000; cyc++) begin
            @(negedge clk);
            heavy = ((cyc / 64) % 2) == 0;
            if (m_ack) pend = 0;
            if (pend && $urandom_range(15) == 0) pend = 0;
            if (!pend && $urandom_range(2) != 0) begin
                pend = 1;
                idx = 8'($urandom_range(128, 255));
                ext_we = 1'($urandom_range(1));
                ext_adr = {22'd0, idx, 2'b00};
                ext_wd = $urandom;
            end
            ext_req = pend;
            cpu_acc = heavy ? ($urandom_range(7) != 0) : ($urandom_range(1) == 0);
            cpu_we = cpu_acc & 1'($urandom_range(1));
            cpu_re = cpu_acc & ~cpu_we;
            idx = 8'($urandom_range(128, 255));
            cpu_adr = {22'd0, idx, 2'b00};
            cpu_wd = $urandom;
            #1;
            gnt     = !m_ack && ext_req && (!cpu_acc || denied >= MAX_WAIT);
            e_stall = cpu_acc && gnt;
            e_a     = gnt ? ext_adr : cpu_adr;
            e_wd    = gnt ? ext_wd : cpu_wd;
            e_we    = gnt ? ext_we : (cpu_we && !e_stall);
            total++; if (cpu_stall !== e_stall) begin bad++; $display("FAIL r_stall cyc=%0d got=%b exp=%b", cyc, cpu_stall, e_stall); end
            total++; if (mem_a !== e_a) begin bad++; $display("FAIL r_mem_a cyc=%0d got=%h exp=%h", cyc, mem_a, e_a); end
            total++; if (mem_we !== e_we) begin bad++; $display("FAIL r_mem_we cyc=%0d got=%b exp=%b", cyc, mem_we, e_we); end
            if (e_we) begin
                total++; if (mem_wd !== e_wd) begin bad++; $display("FAIL r_mem_wd cyc=%0d got=%h exp=%h", cyc, mem_wd, e_wd); end
            end
            total++; if (ext_ack !== m_ack) begin bad++; $display("FAIL r_ack cyc=%0d got=%b exp=%b", cyc, ext_ack, m_ack); end
            total++; if (ext_rd !== exp_rd) begin bad++; $display("FAIL r_ext_rd cyc=%0d got=%h exp=%h", cyc, ext_rd, exp_rd); end
            if (!gnt) begin
                total++; if (cpu_rd !== ref_mem[cpu_adr[9:2]]) begin
                    bad++; $display("FAIL r_cpu_rd cyc=%0d got=%h exp=%h", cyc, cpu_rd, ref_mem[cpu_adr[9:2]]);
                end
            end
            if (gnt) begin
                if (ext_we) ref_mem[ext_adr[9:2]] = ext_wd;
                else        exp_rd = ref_mem[ext_adr[9:2]];
            end else if (cpu_we) begin
                ref_mem[cpu_adr[9:2]] = cpu_wd;
            end
            if (!m_ack) denied = (gnt || !ext_req) ? 0 : ((denied < MAX_WAIT) ? denied + 1 : denied);
            m_ack = gnt;
        end
        @(negedge clk);
        idle_inputs();
        @(negedge clk); #1;
        for (int i = 128; i < 256; i++) begin
            total++; if (dmem[i] !== ref_mem[i]) begin
                bad++; $display("FAIL r_final_mem word=%0d got=%h exp=%h", i, dmem[i], ref_mem[i]);
            end
        end
    endtask

    initial begin
        for (int i = 0; i < 256; i++) begin
            dmem[i]    = 32'h0;
            ref_mem[i] = 32'h0;
        end
        idle_inputs();
        reset = 0;
        test_reset();
        test_ext_write();
        test_ext_read();
        test_starvation();
        test_back_to_back();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
